// File: rtl/twc_pkg.sv
// Shared constants for the bit-serial two's-complement to sign/magnitude decoder.
//   DEF_WIDTH / DEF_CNT_W : default data width and bit-counter width
//   state_e               : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
package twc_pkg;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/twos_comp_decoder_if.sv
// Valid/ready bus for twos_comp_decoder.
//   input side : in_valid, in_ready, in_data (two's-complement operand)
//   output side: out_valid, out_ready, out_sign, out_mag, out_min
//   master = producer/consumer environment, slave = decoder
interface twos_comp_decoder_if
  import twc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_min;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_min
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_min
  );

endinterface

// File: rtl/twc_bit_cell.sv
// Serial negate cell: remembers whether a 1 has been seen in the current word
// and inverts every later bit when the operand is negative.
//   clk, rst_n : clock, async active-low reset
//   start      : clears the seen-one flag for a new word
//   en         : one bit is processed this cycle
//   b, sign    : current operand bit, operand sign
//   out_bit_c  : decoded bit (combinational)
module twc_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  input  logic b,
  input  logic sign,
  output logic out_bit_c
);

  logic seen_one_q;
  logic seen_one_d;

  // Set-only flag; start has priority so a new word never inherits state
  always_comb begin
    seen_one_d = seen_one_q;
    if (start) begin
      seen_one_d = 1'b0;
    end else if (en) begin
      seen_one_d = seen_one_q | b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  // Bits up to and including the first 1 pass through, later ones invert
  assign out_bit_c = b ^ (sign & seen_one_q);

endmodule

// File: rtl/twos_comp_decoder.sv
// Bit-serial two's-complement to sign/magnitude decoder, LSB first.
//   t_clk, t_rst_n : clock, async active-low reset
//   bus (slave)    : in_valid/in_ready/in_data accept side,
//                    out_valid/out_ready/out_sign/out_mag/out_min result side
module twos_comp_decoder
  import twc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic          t_clk,
  input  logic          t_rst_n,
  twos_comp_decoder_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             out_sign_q, out_sign_d;
  logic             min_q, min_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             start_c;
  logic             en_c;
  logic             bit_c;

  twc_bit_cell u_cell (
    .clk       (t_clk),
    .rst_n     (t_rst_n),
    .start     (start_c),
    .en        (en_c),
    .b         (sreg_q[0]),
    .sign      (sign_q),
    .out_bit_c (bit_c)
  );

  // Next-state, datapath and registered handshake outputs
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sign_d     = sign_q;
    sreg_d     = sreg_q;
    mag_d      = mag_q;
    out_sign_d = out_sign_q;
    min_d      = min_q;
    start_c    = 1'b0;
    en_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sreg_d  = bus.in_data;
          sign_d  = bus.in_data[WIDTH-1];
          count_d = '0;
          start_c = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        en_c       = 1'b1;
        sreg_d     = sreg_q >> 1;
        mag_d      = {bit_c, mag_q[WIDTH-1:1]};
        out_sign_d = sign_q;
        count_d    = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) begin
          // Only a negative operand can decode to the lone-MSB magnitude
          min_d   = sign_q && (mag_d == MIN_MAG);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      sign_q      <= 1'b0;
      sreg_q      <= '0;
      mag_q       <= '0;
      out_sign_q  <= 1'b0;
      min_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      sreg_q      <= sreg_d;
      mag_q       <= mag_d;
      out_sign_q  <= out_sign_d;
      min_q       <= min_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_mag   = mag_q;
  assign bus.out_min   = min_q;

endmodule

// File: tb/tb_twos_comp_decoder.sv
// Self-checking bench for twos_comp_decoder: directed vectors, backpressure,
// reset during SHIFT and a random back-to-back stream, all scored through a queue.
module tb_twos_comp_decoder;

  localparam int unsigned W = 12;
  localparam logic [W-1:0] MIN_V = 12'h800;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
    logic         min;
  } exp_t;

  logic t_clk;
  logic t_rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  twos_comp_decoder_if #(.WIDTH(W)) bus ();

  twos_comp_decoder #(.WIDTH(W), .CNT_W(4)) dut (
    .t_clk   (t_clk),
    .t_rst_n (t_rst_n),
    .bus     (bus)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.sign = d[W-1];
    e.mag  = d[W-1] ? W'(~d + W'(1)) : d;
    e.min  = d[W-1] && (d == MIN_V);
    return e;
  endfunction

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  // Waits for in_ready, presents one word for one edge and records the expectation
  task automatic send_word(input logic [W-1:0] d, input exp_t e, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!bus.in_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Counts edges until out_valid rises (bounded)
  task automatic wait_out_valid(input int max, output int n, output bit ok);
    n = 0;
    while (!bus.out_valid && n < max) begin
      tick();
      n++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset();
    t_rst_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #23;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sign !== 1'b0) begin errors++; $display("FAIL reset_out_sign: got %b want 0", bus.out_sign); end
    checks++; if (bus.out_mag !== 12'h000) begin errors++; $display("FAIL reset_out_mag: got %h want 000", bus.out_mag); end
    checks++; if (bus.out_min !== 1'b0) begin errors++; $display("FAIL reset_out_min: got %b want 0", bus.out_min); end
    @(negedge t_clk);
    t_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [W-1:0] vin  [5] = '{12'h000, 12'hFFF, 12'hF9C, 12'h800, 12'h7FF};
    exp_t         vexp [5] = '{
      '{1'b0, 12'h000, 1'b0},
      '{1'b1, 12'h001, 1'b0},
      '{1'b1, 12'h064, 1'b0},
      '{1'b1, 12'h800, 1'b1},
      '{1'b0, 12'h7FF, 1'b0}
    };
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit   ok;
      int   lat;
      exp_t e;
      send_word(vin[i], vexp[i], ok);
      if (!ok) continue;
      wait_out_valid(200, lat, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d_timeout: out_valid=%b required 1", i, bus.out_valid);
        sb.delete();
        continue;
      end
      e = sb.pop_front();
      checks++; if (lat != 12) begin errors++; $display("FAIL vec%0d_latency: got %0d edges want 12", i, lat); end
      checks++; if (bus.out_sign !== e.sign) begin errors++; $display("FAIL vec%0d_sign: got %b want %b", i, bus.out_sign, e.sign); end
      checks++; if (bus.out_mag !== e.mag) begin errors++; $display("FAIL vec%0d_mag: got %h want %h", i, bus.out_mag, e.mag); end
      checks++; if (bus.out_min !== e.min) begin errors++; $display("FAIL vec%0d_min: got %b want %b", i, bus.out_min, e.min); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_valid_drop: got %b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   lat;
    int   extra;
    exp_t e;
    bus.out_ready = 1'b0;
    send_word(12'h9AB, '{1'b1, 12'h655, 1'b0}, ok);
    if (!ok) return;
    wait_out_valid(200, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b required 1", bus.out_valid);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 12'h123;
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_mag !== e.mag) begin errors++; $display("FAIL bp_hold_mag%0d: got %h want %h", i, bus.out_mag, e.mag); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_sign !== e.sign) begin errors++; $display("FAIL bp_sign: got %b want %b", bus.out_sign, e.sign); end
    checks++; if (bus.out_min !== e.min) begin errors++; $display("FAIL bp_min: got %b want %b", bus.out_min, e.min); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
    // None of the pulsed words may have been taken
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.out_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_no_accept: out_valid seen %0d cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_shift();
    bit   ok;
    int   lat;
    int   extra;
    exp_t e;
    bus.out_ready = 1'b1;
    send_word(12'h555, model(12'h555), ok);
    if (!ok) return;
    for (int i = 0; i < 5; i++) tick();
    t_rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sign !== 1'b0) begin errors++; $display("FAIL rst_mid_out_sign: got %b want 0", bus.out_sign); end
    checks++; if (bus.out_mag !== 12'h000) begin errors++; $display("FAIL rst_mid_out_mag: got %h want 000", bus.out_mag); end
    checks++; if (bus.out_min !== 1'b0) begin errors++; $display("FAIL rst_mid_out_min: got %b want 0", bus.out_min); end
    tick();
    t_rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.out_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rst_mid_no_pulse: out_valid seen %0d cycles want 0", extra); end
    send_word(12'hFFE, '{1'b1, 12'h002, 1'b0}, ok);
    if (!ok) return;
    wait_out_valid(200, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_next_timeout: out_valid=%b required 1", bus.out_valid);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    checks++; if (bus.out_sign !== e.sign) begin errors++; $display("FAIL rst_next_sign: got %b want %b", bus.out_sign, e.sign); end
    checks++; if (bus.out_mag !== e.mag) begin errors++; $display("FAIL rst_next_mag: got %h want %h", bus.out_mag, e.mag); end
    checks++; if (bus.out_min !== e.min) begin errors++; $display("FAIL rst_next_min: got %b want %b", bus.out_min, e.min); end
    tick();
  endtask

  task automatic test_back_to_back();
    int got;
    int extra;
    got = 0;
    fork
      begin : driver
        for (int i = 0; i < 50; i++) begin
          bit           ok;
          logic [W-1:0] d;
          d = W'($urandom);
          if (i == 10) d = 12'h800;
          if (i == 20) d = 12'h000;
          send_word(d, model(d), ok);
        end
      end
      begin : monitor
        int budget;
        budget = 0;
        while (got < 50 && budget < 20000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL b2b_spurious: result %h with empty scoreboard", bus.out_mag);
            end else begin
              e = sb.pop_front();
              checks++; if (bus.out_sign !== e.sign) begin errors++; $display("FAIL b2b%0d_sign: got %b want %b", got, bus.out_sign, e.sign); end
              checks++; if (bus.out_mag !== e.mag) begin errors++; $display("FAIL b2b%0d_mag: got %h want %h", got, bus.out_mag, e.mag); end
              checks++; if (bus.out_min !== e.min) begin errors++; $display("FAIL b2b%0d_min: got %b want %b", got, bus.out_min, e.min); end
            end
            got++;
          end
          tick();
          budget++;
        end
      end
    join
    bus.out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) extra++;
    end
    checks++; if (got != 50) begin errors++; $display("FAIL b2b_count: got %0d results want 50", got); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: %0d expected results pending want 0", sb.size()); end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate: out_valid seen %0d cycles after stream want 0", extra); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
